divu32_iter: RTL and testbench
==============================

Name: divu32_iter

Overview:
- Iterative unsigned 32-bit divider for the ALU.
- Performs the inverse of the adder datapath: restoring division by repeated trial subtraction, one quotient bit per clock.
- Each trial subtraction runs on a single add32 instance used as a subtractor: a + ~b with c_in = 1.
- Sits beside the ALU. Operands arrive and results leave through valid/ready handshakes.

Parameters:
- N, 32: operand width. Only 32 is supported, because the datapath uses the fixed-width add32.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands (high only in IDLE)
- dividend  input  N  unsigned numerator
- divisor  input  N  unsigned denominator
- out_valid  output  1  result present (high only in DONE)
- out_ready  input  1  consumer accepts result
- quotient  output  N  unsigned quotient
- remainder  output  N  unsigned remainder
- div_by_zero  output  1  divisor was 0 for this result

Behaviour:
- Reset (synchronous, active-high), sampled on a clk edge:
  - state goes to IDLE;
  - quotient, remainder, div_by_zero, out_valid and the internal registers go to 0;
  - in_ready is 1 in the cycle after reset deasserts.
- Reset during RUN or DONE aborts the operation. No result is emitted and the operands are discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch dividend into the Q register, divisor into the D register, clear the R register (N+1 bits) and set count = N-1.
  - If divisor == 0, go directly to DONE with quotient = all ones (0xFFFFFFFF), remainder = dividend, div_by_zero = 1.
  - Otherwise go to RUN.
- RUN, one iteration per cycle:
  - shifted = {R[N-1:0], Q[N-1]};
  - trial = shifted[N-1:0] + ~D + 1, computed through add32, giving carry c.
  - Accept the subtraction when shifted[N] | c.
  - If accepted: R = {0, trial} and Q = {Q[N-2:0], 1}. Otherwise: R = shifted and Q = {Q[N-2:0], 0}.
  - When count == 0, go to DONE; otherwise decrement count.
  - Exactly N cycles are spent in RUN.
- DONE:
  - out_valid = 1; quotient = Q; remainder = R[N-1:0]; div_by_zero is as latched.
  - Outputs stay stable while out_valid & !out_ready (backpressure holds indefinitely).
  - On out_valid & out_ready, go to IDLE. out_valid drops the next cycle. quotient and remainder keep their last values until the next result.
- Latency, with acceptance at edge 0:
  - normal: out_valid high from edge N+1 (33 cycles);
  - divide-by-zero: out_valid high from edge 1.
- Throughput: one division per N+2 cycles at best. No new operand is accepted in RUN or DONE (in_ready = 0).
- in_valid in RUN or DONE is ignored and must not corrupt state.
- Invariants:
  - quotient*divisor + remainder == dividend, with remainder < divisor, whenever div_by_zero = 0;
  - no overflow is possible for unsigned division.
- The N+1-bit R register is required: the shifted partial remainder can reach 2*D-1, which exceeds N bits when D > 2^(N-1).

Decomposition:
- Shared package alu_pkg:
  - typedef enum logic [1:0] div_state_t {IDLE, RUN, DONE};
  - localparam DIV_N = 32;
  - localparam DIV_CNT_W = 5.
- Sub-module: one instance of the existing add32, used as the trial subtractor (operand b = ~D, c_in = 1).
- No other sub-modules. The FSM, shift registers and counter live in divu32_iter.

Test Plan:
- dividend=100, divisor=7, out_ready=1 -> out_valid high exactly 33 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0.
- dividend=0xFFFFFFFF, divisor=0x80000001 (exercises the R[N] carry path) -> quotient=1, remainder=0x7FFFFFFE. Also dividend=0xFFFFFFFF, divisor=1 -> quotient=0xFFFFFFFF, remainder=0.
- dividend=5, divisor=0 -> out_valid 1 cycle after acceptance; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
- dividend=7, divisor=9 -> quotient=0, remainder=7.
- Backpressure: 1000/10 with out_ready=0 for 10 cycles after out_valid -> quotient=100 and remainder=0 stay stable. in_ready stays 0 and a second in_valid is ignored. out_ready=1 -> IDLE next cycle.
- Reset: rst=1 at cycle 12 of RUN -> next cycle in IDLE, in_ready=1, out_valid=0, quotient=remainder=0. A following 81/9 -> quotient=9, remainder=0.
- Random: 1000 random pairs (including divisor 0 and 1) checked against the $ reference model and the invariant.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU types and constants for the iterative divider
package alu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

  localparam int DIV_N     = 32;
  localparam int DIV_CNT_W = 5;

endpackage

// File: rtl/add32.sv
// rtl/add32.sv - 32-bit ripple adder with carry in and carry out
module add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);

  logic [32:0] total;

  always_comb begin
    total = {1'b0, a} + {1'b0, b} + {32'd0, c_in};
  end

  assign sum   = total[31:0];
  assign c_out = total[32];

endmodule

// File: rtl/divu32_iter.sv
// rtl/divu32_iter.sv - restoring unsigned 32-bit divider, one quotient bit per clock
module divu32_iter
  import alu_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  div_state_t           state_q, state_d;
  logic [N-1:0]         q_q, q_d;
  logic [N-1:0]         d_q, d_d;
  logic [N:0]           r_q, r_d;
  logic [DIV_CNT_W-1:0] count_q, count_d;
  logic [N-1:0]         quot_q, quot_d;
  logic [N-1:0]         rem_q, rem_d;
  logic                 dbz_q, dbz_d;

  logic [N:0]   shifted;
  logic [N-1:0] trial;
  logic         carry;
  logic         accept;
  logic         unused_r_msb;

  assign shifted = {r_q[N-1:0], q_q[N-1]};

  // Trial subtraction shifted - D as shifted + ~D + 1; carry out means no borrow.
  add32 u_sub (
    .a     (shifted[N-1:0]),
    .b     (~d_q),
    .c_in  (1'b1),
    .sum   (trial),
    .c_out (carry)
  );

  assign accept = shifted[N] | carry;

  // R[N] is always cleared after a step; its weight is consumed through shifted[N].
  assign unused_r_msb = r_q[N];

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    d_d     = d_q;
    r_d     = r_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          q_d     = dividend;
          d_d     = divisor;
          r_d     = '0;
          count_d = DIV_CNT_W'(N - 1);
          if (divisor == '0) begin
            quot_d  = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (accept) begin
          r_d = {1'b0, trial};
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[N-2:0], 1'b0};
        end
        if (count_q == '0) begin
          quot_d  = q_d;
          rem_d   = r_d[N-1:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      q_q     <= '0;
      d_q     <= '0;
      r_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      d_q     <= d_d;
      r_q     <= r_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divu32_iter.sv
// tb/tb_divu32_iter.sv - scoreboard bench for divu32_iter
module tb_divu32_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  divu32_iter dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one operand pair for a single accepting edge; optionally score it.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input bit push);
    exp_t e;
    int   t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_send", in_ready, 1);
    e.a   = a;
    e.b   = b;
    e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
    e.r   = (b == 0) ? a : a % b;
    e.dbz = (b == 0);
    if (push) sb.push_back(e);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Wait for out_valid, reporting edges since acceptance, then score the result.
  task automatic collect(output int lat);
    exp_t        e;
    logic [63:0] prod;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", out_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'(sb.size()), 1);
      return;
    end
    e = sb.pop_front();
    check("quotient", quotient, e.q);
    check("remainder", remainder, e.r);
    check("div_by_zero", div_by_zero, e.dbz);
    if (!e.dbz) begin
      prod = 64'(quotient) * 64'(e.b) + 64'(remainder);
      check("invariant", prod, 64'(e.a));
      check("rem_lt_div", 64'(remainder < e.b), 1);
    end
  endtask

  task automatic run_one(input logic [31:0] a, input logic [31:0] b, input int exp_lat);
    int lat;
    send(a, b, 1'b1);
    collect(lat);
    if (exp_lat > 0) check("latency", 64'(lat), 64'(exp_lat));
    @(negedge clk);
    if (exp_lat > 0) check("out_valid_drop", out_valid, 0);
  endtask

  initial begin
    int          lat;
    logic [31:0] ra, rb;

    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    run_one(32'd100, 32'd7, 33);
    run_one(32'hFFFF_FFFF, 32'h8000_0001, 33);
    run_one(32'hFFFF_FFFF, 32'd1, 33);
    run_one(32'd5, 32'd0, 1);
    run_one(32'd7, 32'd9, 33);

    // Backpressure with a stray request while DONE is held.
    out_ready = 1'b0;
    send(32'd1000, 32'd10, 1'b1);
    collect(lat);
    check("bp_latency", 64'(lat), 33);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_valid = 1'b1;
        dividend = 32'd55;
        divisor  = 32'd0;
      end
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_quotient", quotient, 32'd100);
      check("bp_remainder", remainder, 32'd0);
      check("bp_dbz", div_by_zero, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    check("bp_hold_quotient", quotient, 32'd100);

    // Reset in the middle of RUN discards the operation.
    send(32'd100, 32'd7, 1'b0);
    repeat (11) @(negedge clk);
    check("mid_run_busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_quotient", quotient, 0);
    check("abort_remainder", remainder, 0);
    rst = 1'b0;
    @(negedge clk);
    run_one(32'd81, 32'd9, 33);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 9))
        0:       rb = 32'd0;
        1:       rb = 32'd1;
        2:       rb = 32'($urandom_range(2, 255));
        3:       rb = 32'h8000_0000 | $urandom;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 3) == 0) out_ready = 1'b0;
      send(ra, rb, 1'b1);
      collect(lat);
      check("rand_latency", 64'(lat), (rb == 0) ? 64'd1 : 64'd33);
      out_ready = 1'b1;
      @(negedge clk);
    end

    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
